// File: rtl/sat_search_pkg.sv
// Shared definitions for the brute-force SAT search engine:
// state encoding, counter width helper and the deepest supported oracle pipeline.
package sat_search_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int MAX_LAT = 4;

  // Counters must reach 2^n, so they need one bit more than the assignment.
  function automatic int cnt_w(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/sat_oracle_search_if.sv
// Bundle between the search engine (master) and the host plus oracle (slave).
// sol_count_o exists only when SEARCH_COUNT_ALL_EN is defined.
interface sat_oracle_search_if #(
  parameter int NUM_VARS = 7
);
  import sat_search_pkg::*;

  localparam int CW = cnt_w(NUM_VARS);

  logic                start_i;
  logic                abort_i;
  logic                sat_i;
  logic [NUM_VARS-1:0] assign_o;
  logic                busy_o;
  logic                done_o;
  logic                result_o;
  logic [NUM_VARS-1:0] model_o;
  logic [CW-1:0]       checked_o;
`ifdef SEARCH_COUNT_ALL_EN
  logic [CW-1:0]       sol_count_o;
`endif

  modport master (
    input  start_i, abort_i, sat_i,
    output assign_o, busy_o, done_o, result_o, model_o, checked_o
`ifdef SEARCH_COUNT_ALL_EN
    , output sol_count_o
`endif
  );

  modport slave (
    output start_i, abort_i, sat_i,
    input  assign_o, busy_o, done_o, result_o, model_o, checked_o
`ifdef SEARCH_COUNT_ALL_EN
    , input sol_count_o
`endif
  );

endinterface

// File: rtl/sat_search_pipe.sv
// Valid+candidate delay line matching the oracle latency; DEPTH = 0 is a plain wire.
// flush_i synchronously invalidates every stage, including the entry being pushed.
module sat_search_pipe #(
  parameter int W     = 7,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_cand_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_cand_o,
  output logic         pending_o
);

  logic [DEPTH:0]        v_chain;
  logic [DEPTH:0][W-1:0] c_chain;

  assign v_chain[0] = in_valid_i;
  assign c_chain[0] = in_cand_i;

  genvar gi;
  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_sink;
      assign unused_sink = ^{clk, reset, flush_i};
      assign pending_o   = 1'b0;
    end else begin : g_regs
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic         v_q, v_d;
        logic [W-1:0] c_q, c_d;

        always_comb begin
          v_d = flush_i ? 1'b0 : v_chain[gi];
          c_d = c_chain[gi];
        end

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            v_q <= 1'b0;
            c_q <= '0;
          end else begin
            v_q <= v_d;
            c_q <= c_d;
          end
        end

        assign v_chain[gi+1] = v_q;
        assign c_chain[gi+1] = c_q;
      end
      assign pending_o = |v_chain[DEPTH:1];
    end
  endgenerate

  assign out_valid_o = v_chain[DEPTH];
  assign out_cand_o  = c_chain[DEPTH];

endmodule

// File: rtl/sat_oracle_search.sv
// Brute-force SAT search: enumerates all assignments into an oracle and reports the first model or UNSAT.
// Optional macro SEARCH_COUNT_ALL_EN: keep searching after hits and count every satisfying assignment.
module sat_oracle_search
  import sat_search_pkg::*;
#(
  parameter int NUM_VARS   = 7,
  parameter int ORACLE_LAT = 0
) (
  input logic                 clk,
  input logic                 reset,
  sat_oracle_search_if.master bus
);

  localparam int                  CW   = cnt_w(NUM_VARS);
  localparam int                  LAT  = (ORACLE_LAT > MAX_LAT) ? MAX_LAT : ORACLE_LAT;
  localparam logic [NUM_VARS-1:0] LAST = '1;

  state_t              state_q, state_d;
  logic [NUM_VARS-1:0] cnt_q, cnt_d;
  logic [NUM_VARS-1:0] model_q, model_d;
  logic [CW-1:0]       checked_q, checked_d;
  logic                result_q, result_d;
  logic                flush, tail_valid, pending, hit;
  logic [NUM_VARS-1:0] tail_cand;
`ifdef SEARCH_COUNT_ALL_EN
  logic [CW-1:0]       sol_q, sol_d;
`endif

  assign hit = tail_valid & bus.sat_i;

  sat_search_pipe #(
    .W     (NUM_VARS),
    .DEPTH (LAT)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .in_valid_i  (state_q == RUN),
    .in_cand_i   (cnt_q),
    .out_valid_o (tail_valid),
    .out_cand_o  (tail_cand),
    .pending_o   (pending)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    model_d   = model_q;
    checked_d = checked_q;
    result_d  = result_q;
    flush     = 1'b0;
`ifdef SEARCH_COUNT_ALL_EN
    sol_d     = sol_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          state_d   = RUN;
          cnt_d     = '0;
          model_d   = '0;
          checked_d = '0;
          result_d  = 1'b0;
          flush     = 1'b1;
`ifdef SEARCH_COUNT_ALL_EN
          sol_d     = '0;
`endif
        end
      end
      RUN, DRAIN: begin
        if (tail_valid) checked_d = checked_q + 1'b1;
        if (state_q == RUN) begin
          // Counter saturates on the last candidate; the pipe then drains.
          if (cnt_q == LAST) state_d = DRAIN;
          else               cnt_d   = cnt_q + 1'b1;
        end else if (!pending) begin
          state_d = DONE;
`ifdef SEARCH_COUNT_ALL_EN
          result_d = (sol_q != '0);
`endif
        end
`ifdef SEARCH_COUNT_ALL_EN
        if (hit) begin
          sol_d = sol_q + 1'b1;
          if (sol_q == '0) model_d = tail_cand;
        end
`else
        if (hit) begin
          state_d  = DONE;
          cnt_d    = cnt_q;
          model_d  = tail_cand;
          result_d = 1'b1;
          flush    = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides start and any same-cycle hit; assign_o keeps its value.
    if (bus.abort_i) begin
      state_d   = IDLE;
      cnt_d     = cnt_q;
      model_d   = '0;
      checked_d = '0;
      result_d  = 1'b0;
      flush     = 1'b1;
`ifdef SEARCH_COUNT_ALL_EN
      sol_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      model_q   <= '0;
      checked_q <= '0;
      result_q  <= 1'b0;
`ifdef SEARCH_COUNT_ALL_EN
      sol_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      model_q   <= model_d;
      checked_q <= checked_d;
      result_q  <= result_d;
`ifdef SEARCH_COUNT_ALL_EN
      sol_q     <= sol_d;
`endif
    end
  end

  assign bus.assign_o  = cnt_q;
  assign bus.busy_o    = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done_o    = (state_q == DONE);
  assign bus.result_o  = result_q;
  assign bus.model_o   = model_q;
  assign bus.checked_o = checked_q;
`ifdef SEARCH_COUNT_ALL_EN
  assign bus.sol_count_o = sol_q;
`endif

endmodule
